cnt_share_arb: RTL

- Round-robin arbiter and sequencer that shares one 5-bit signed up-counter between N_REQ requesters.
- Each granted requester gets one counting run from 0 up to its programmed target. The block then ends the run, clears the counter and moves to the next requester.
- Sits between the requester logic and the shared counter. It owns the counter's enable and observes the counter's value.
- Counter contract:
  - Synchronous active-high reset loads -5.
  - en=0 clears the counter to 0 on the next edge.
  - en=1 increments the counter.
  - A value of 15 wraps to 0.

---
 rtl/cnt_share_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cnt_share_arb.sv
// Round-robin sequencer that lends one shared 5-bit signed up-counter to N_REQ
// requesters, one counting run per grant, and cross-checks the counter against a shadow.
module cnt_share_arb #(
    parameter  int N_REQ = 4,
    parameter  int LEN_W = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   len_flat,
    input  logic signed [4:0]        cnt_val,
    output logic                     cnt_en,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic                     done_err,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   cur_id_r;
    logic [LEN_W-1:0]  target_r;
    logic [4:0]        shadow_r;

    logic [ID_W-1:0]   pick_s;
    logic              found_s;
    logic [LEN_W-1:0]  pick_len_s;
    logic [LEN_W-1:0]  pick_tgt_s;
    logic [ID_W-1:0]   ptr_next_s;
    logic              mismatch_s;
    logic              at_target_s;

    // Round-robin search: first set req bit at or after ptr, wrapping at N_REQ.
    always_comb begin
        logic [ID_W:0]   sum_v;
        logic [ID_W-1:0] idx_v;
        logic            hit_v;
        pick_s  = {ID_W{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_v   = {1'b0, ptr_r} + (ID_W+1)'(k);
            idx_v   = (sum_v >= (ID_W+1)'(N_REQ)) ? ID_W'(sum_v - (ID_W+1)'(N_REQ))
                                                  : ID_W'(sum_v);
            hit_v   = !found_s && req[idx_v];
            pick_s  = hit_v ? idx_v : pick_s;
            found_s = found_s | hit_v;
        end
    end

    // Run length of the candidate requester; a zero length still gets one RUN cycle.
    always_comb begin
        pick_len_s = {LEN_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            pick_len_s = (pick_s == ID_W'(i)) ? len_flat[i*LEN_W +: LEN_W] : pick_len_s;
        end
        pick_tgt_s = (pick_len_s == {LEN_W{1'b0}}) ? LEN_W'(1'b1) : pick_len_s;
    end

    assign ptr_next_s  = (cur_id_r == ID_W'(N_REQ-1)) ? {ID_W{1'b0}} : cur_id_r + ID_W'(1'b1);
    assign mismatch_s  = (cnt_val != $signed(shadow_r));
    assign at_target_s = (int'(cnt_val) == (int'(target_r) - 32'sd1));

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {ID_W{1'b0}};
            cur_id_r <= {ID_W{1'b0}};
            target_r <= LEN_W'(1'b1);
            shadow_r <= 5'd0;
            cnt_en   <= 1'b0;
            grant    <= {N_REQ{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= {ID_W{1'b0}};
            done_err <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s && (cnt_val == 5'sd0)) begin
                        state_r  <= ST_RUN;
                        cur_id_r <= pick_s;
                        target_r <= pick_tgt_s;
                        shadow_r <= 5'd0;
                        cnt_en   <= 1'b1;
                        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    shadow_r <= shadow_r + 5'd1;
                    // A counter that disagrees with the shadow ends the run before the target compare.
                    if (mismatch_s) begin
                        state_r  <= ST_DONE;
                        cnt_en   <= 1'b0;
                        done     <= 1'b1;
                        done_id  <= cur_id_r;
                        done_err <= 1'b1;
                        err      <= 1'b1;
                    end else if (at_target_s) begin
                        state_r  <= ST_DONE;
                        cnt_en   <= 1'b0;
                        done     <= 1'b1;
                        done_id  <= cur_id_r;
                        done_err <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    ptr_r    <= ptr_next_s;
                    grant    <= {N_REQ{1'b0}};
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    done_err <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_en   <= 1'b0;
                    grant    <= {N_REQ{1'b0}};
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    done_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
